spi_slave: RTL and testbench
============================

# spi_slave

SPI responder for the SPI protocol project: the far end of the existing SPI master, sitting on the Spartan 6 board's SPI pins. It oversamples `spi_clk`, `cs` and `mosi` in the system `clk` domain, supports all four polarity/phase modes, and assembles 8-bit MSB-first frames from `mosi` into a parallel byte with a valid pulse. It also shifts a preloaded byte out on `miso` during the same frame.

## Interface
- `DATA_W`, 8: frame width in bits; `count` width is `$clog2(DATA_W)+1`.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_clk`, `cs` and `mosi`.
- `clk`  in  1  system clock. Must be ≥ 2·(SYNC_STAGES+1)× `spi_clk`.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `polarity`  in  1  CPOL, spi_clk idle level.
- `phase`  in  1  CPHA: 0 = sample on leading edge; 1 = sample on trailing edge.
- `spi_clk`  in  1  serial clock from master (asynchronous to `clk`).
- `cs`  in  1  chip select, active low.
- `mosi`  in  1  serial data from master.
- `miso`  out  1  serial data to master. Idles at 1.
- `data_wr`  in  DATA_W  byte to transmit in the next frame.
- `wr_load`  in  1  writes `data_wr` into the TX buffer when `wr_ready`=1.
- `wr_ready`  out  1  TX buffer empty.
- `data_rd`  out  DATA_W  last complete received frame.
- `rd_valid`  out  1  one-`clk` pulse: `data_rd` updated.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `state`  out  2  FSM state, for debug.
- `count`  out  4  bits remaining in the current frame.

## Operation
- `spi_mode = {polarity, phase}` is latched on the synchronized `cs` falling edge. Changing it while `cs`=0 has no effect on the current frame.
- **Edges:**
  - The leading edge is rising when polarity=0 and falling when polarity=1. The trailing edge is the opposite.
  - The sample edge is the leading edge when phase=0 and the trailing edge when phase=1. The shift edge is the other one.
- **FSM states:**
  - IDLE: `miso`=1, `count`=DATA_W. A synchronized `cs` fall moves to LOAD.
  - LOAD (1 cycle):
    - Load the TX shift register from the TX buffer, or from all-ones if `wr_ready`=1 (empty). Mark the buffer empty.
    - Reset `count` to DATA_W.
    - If phase=0, drive the MSB onto `miso` now.
    - Go to SHIFT.
  - SHIFT:
    - On the sample edge: shift synchronized `mosi` into the RX register LSB and decrement `count`.
    - On the shift edge: drive the next TX bit, MSB first. With phase=1, the first shift edge drives the MSB. With phase=0, the shift edge after the last sample is ignored.
    - When `count` reaches 0, go to DONE.
  - DONE (1 cycle): `data_rd` ← RX register and pulse `rd_valid`. Go to LOAD if `cs`=0 (back-to-back frames), else IDLE.
- **`cs` rising in SHIFT (abort):**
  - Go to IDLE next cycle, with `count`=DATA_W and `miso`=1.
  - No `rd_valid`; `data_rd` is unchanged.
  - The TX buffer stays consumed.
- **TX buffer handshake:**
  - `wr_load`=1 with `wr_ready`=1 captures `data_wr`; `wr_ready`=0 next cycle.
  - `wr_load` while `wr_ready`=0 is ignored.
  - `wr_load` in the same cycle as LOAD consumes the buffer: the old content is sent and the new byte is captured.
- **Reset:** all outputs take their reset values immediately, independent of `clk`, including mid-frame.
  - `miso`=1, `wr_ready`=1, `data_rd`=0, `rd_valid`=0, `busy`=0, `state`=IDLE, `count`=DATA_W.
  - The TX buffer is cleared to empty.

## Timing
- Each synchronized pin edge is detected SYNC_STAGES+1 `clk` cycles after the pin edge.
- `rd_valid` rises SYNC_STAGES+2 cycles after the 8th sample edge at the pin.
- `miso` changes SYNC_STAGES+1 cycles after a shift edge at the pin. The master must sample no earlier than half an `spi_clk` period later.
- `cs` setup before the first `spi_clk` edge: ≥ SYNC_STAGES+3 `clk` cycles.
- Minimum `spi_clk` half-period: SYNC_STAGES+1 `clk` cycles.

## Configuration
- `SPI_SLAVE_MISO_EN`
  - Defined: full-duplex operation as above.
  - Undefined: receive-only. The TX shift register, TX buffer and `wr_load` logic are removed, `miso` is tied to 1, and `wr_ready` is tied to 0.

## Structure
- Shared package `spi_pkg`:
  - mode encodings MODE0..MODE3
  - FSM state constants IDLE=0, LOAD=1, SHIFT=2, DONE=3
  - default DATA_W and SYNC_STAGES
- Sub-module `spi_edge_sync`: SYNC_STAGES-flop synchronizer plus rise/fall pulse detector. Instantiated for `spi_clk` and `cs`; `mosi` uses the synchronizer only.

## Test plan
- Mode 0, `wr_load` 0x3C, master sends 0xA5 → `data_rd`=0xA5 with one `rd_valid` pulse; master receives 0x3C on `miso`.
- Modes 1, 2 and 3, each with master byte 0x5A and TX 0xC3 → `data_rd`=0x5A and master receives 0xC3 in every mode.
- No `wr_load`, then a frame with master byte 0x81 → master receives 0xFF, `data_rd`=0x81, `wr_ready` stays 1.
- `cs` high after 4 bits of 0xF0 → no `rd_valid`, `data_rd` unchanged, `count`=8, `state`=IDLE, `miso`=1.
- Two back-to-back frames 0x11 and 0x22 with `cs` held low, reloading via `wr_load` between them → two `rd_valid` pulses carrying 0x11 then 0x22.
- `reset` asserted mid-frame, asynchronously → all outputs at reset values before the next `clk` edge; the next full frame 0x77 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: mode and FSM state encodings,
// default frame width / synchronizer depth, and mode decode helpers.
package spi_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // {polarity, phase}
  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_t;

  // Idle level of spi_clk; leading edge is rising when this is 0.
  function automatic logic cpol(input spi_mode_t m);
    return m[1];
  endfunction

  // Sample on the trailing edge when set, on the leading edge otherwise.
  function automatic logic sample_on_trailing(input spi_mode_t m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Pin and host-side bundle of the SPI responder. The slave modport is the
// responder's view; the master modport is the view of whatever drives it.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic              polarity;
  logic              phase;
  logic              spi_clk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] data_wr;
  logic              wr_load;
  logic              wr_ready;
  logic [DATA_W-1:0] data_rd;
  logic              rd_valid;
  logic              busy;
  logic [1:0]        state;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  polarity, phase, spi_clk, cs, mosi, data_wr, wr_load,
    output miso, wr_ready, data_rd, rd_valid, busy, state, count
  );

  modport master (
    output polarity, phase, spi_clk, cs, mosi, data_wr, wr_load,
    input  miso, wr_ready, data_rd, rd_valid, busy, state, count
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin plus a one-cycle
// rise/fall pulse detector on the synchronized level.
module spi_edge_sync
  import spi_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchronizer and keep the previous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, d_i});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples spi_clk/cs/mosi in the clk domain, supports
// all four CPOL/CPHA modes, assembles MSB-first frames into data_rd with a
// rd_valid pulse and, when SPI_SLAVE_MISO_EN is defined, shifts a
// preloaded byte out on miso. Without SPI_SLAVE_MISO_EN it is
// receive-only: miso is tied to 1 and wr_ready to 0.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  spi_slave_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;
  logic lead_p, trail_p, sample_p, shift_p;
  logic unused_ok;

  logic [SYNC_STAGES-1:0] mosi_q;

  spi_state_t        state_q;
  spi_mode_t         mode_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] data_rd_q;
  logic              rd_valid_q;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus.spi_clk),
    .q_o    (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus.cs),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // mosi only needs the level, sampled on the synchronized spi_clk edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= SYNC_STAGES'({mosi_q, bus.mosi});
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // Edge roles follow the mode latched at the start of the frame.
  assign lead_p   = cpol(mode_q) ? sclk_fall : sclk_rise;
  assign trail_p  = cpol(mode_q) ? sclk_rise : sclk_fall;
  assign sample_p = sample_on_trailing(mode_q) ? trail_p : lead_p;
  assign shift_p  = sample_on_trailing(mode_q) ? lead_p  : trail_p;

`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_W-1:0] tx_q;
  logic              miso_q;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] tx_load;

  // An empty buffer sends all-ones.
  assign tx_load = full_q ? buf_q : '1;

  // LOAD always empties the buffer; a write in that same cycle refills it.
  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    if (state_q == LOAD) begin
      full_d = 1'b0;
    end
    if (bus.wr_load && (!full_q || state_q == LOAD)) begin
      buf_d  = bus.data_wr;
      full_d = 1'b1;
    end
  end

  // TX holding buffer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      full_q <= full_d;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.wr_ready = ~full_q;
  assign unused_ok    = ^{sclk_s, cs_rise};
`else
  assign bus.miso     = 1'b1;
  assign bus.wr_ready = 1'b0;
  assign unused_ok    = ^{sclk_s, cs_rise, shift_p, bus.data_wr, bus.wr_load};
`endif

  // Frame FSM: IDLE -> LOAD -> SHIFT -> DONE, with cs-high abort from SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      count_q    <= CNT_FULL;
      rx_q       <= '0;
      data_rd_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
      tx_q       <= '1;
      miso_q     <= 1'b1;
`endif
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= CNT_FULL;
`ifdef SPI_SLAVE_MISO_EN
          miso_q  <= 1'b1;
`endif
          if (cs_fall) begin
            mode_q  <= spi_mode_t'({bus.polarity, bus.phase});
            state_q <= LOAD;
          end
        end
        LOAD: begin
          count_q <= CNT_FULL;
`ifdef SPI_SLAVE_MISO_EN
          // Phase 0: the MSB must be on the line before the first sample.
          if (!sample_on_trailing(mode_q)) begin
            miso_q <= tx_load[DATA_W-1];
            tx_q   <= {tx_load[DATA_W-2:0], 1'b1};
          end else begin
            tx_q   <= tx_load;
          end
`endif
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (cs_s) begin
            state_q <= IDLE;
            count_q <= CNT_FULL;
`ifdef SPI_SLAVE_MISO_EN
            miso_q  <= 1'b1;
`endif
          end else begin
            if (sample_p) begin
              rx_q    <= {rx_q[DATA_W-2:0], mosi_s};
              count_q <= count_q - CNT_W'(1);
              if (count_q == CNT_W'(1)) begin
                state_q <= DONE;
              end
            end
`ifdef SPI_SLAVE_MISO_EN
            // In phase 0 the MSB went out in LOAD, so a shift edge seen
            // before any sample is the previous frame's tail and is skipped.
            if (shift_p && (sample_on_trailing(mode_q) || count_q != CNT_FULL)) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= {tx_q[DATA_W-2:0], 1'b1};
            end
`endif
          end
        end
        DONE: begin
          data_rd_q  <= rx_q;
          rd_valid_q <= 1'b1;
          if (cs_s) begin
            state_q <= IDLE;
`ifdef SPI_SLAVE_MISO_EN
            miso_q  <= 1'b1;
`endif
          end else begin
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_rd  = data_rd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.state    = state_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a timed SPI master drives frames in all modes and a
// byte-level model (TX buffer occupancy, expected received/transmitted
// bytes) predicts data_rd, rd_valid pulses, miso bytes and idle outputs.
module tb_spi_slave;

`ifdef SPI_SLAVE_MISO_EN
  localparam bit TX_EN = 1'b1;
`else
  localparam bit TX_EN = 1'b0;
`endif
  localparam int HALF = 6;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   rv_hi  = 0;

  // Model state
  bit         buf_full = 1'b0;
  logic [7:0] buf_val  = 8'h00;
  logic [7:0] exp_tx   = 8'hFF;
  logic [7:0] exp_rd   = 8'h00;

  spi_slave_if bus ();

  spi_slave dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) rv_hi++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // A frame start takes whatever the buffer holds (all-ones when empty).
  task automatic m_start(output logic [7:0] tx);
    tx = (TX_EN && buf_full) ? buf_val : 8'hFF;
    buf_full = 1'b0;
  endtask

  task automatic m_load(input logic [7:0] v);
    if (TX_EN && !buf_full) begin
      buf_full = 1'b1;
      buf_val  = v;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus.data_wr = v;
    bus.wr_load = 1'b1;
    m_load(v);
    @(negedge clk);
    bus.wr_load = 1'b0;
  endtask

  task automatic spi_frame(input logic [1:0] mode, input logic [7:0] mb, input int nbits,
                           input bit first, input bit hold, output logic [7:0] mrx);
    logic pol, pha;
    pol = mode[1];
    pha = mode[0];
    mrx = 8'h00;
    if (first) begin
      @(negedge clk);
      bus.polarity = pol;
      bus.phase    = pha;
      bus.spi_clk  = pol;
      bus.mosi     = pha ? 1'b0 : mb[7];
      repeat (6) @(negedge clk);
      bus.cs = 1'b0;
      repeat (8) @(negedge clk);
    end else begin
      if (!pha) bus.mosi = mb[7];
      repeat (HALF) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      bus.spi_clk = ~pol;
      if (pha) bus.mosi = mb[7-i];
      else     mrx = {mrx[6:0], bus.miso};
      repeat (HALF) @(negedge clk);
      bus.spi_clk = pol;
      if (pha)        mrx = {mrx[6:0], bus.miso};
      else if (i < 7) bus.mosi = mb[6-i];
      repeat (HALF) @(negedge clk);
    end
    if (!hold) begin
      bus.cs = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic do_frame(input logic [1:0] mode, input logic [7:0] mb, input int nbits,
                          input bit first, input bit hold);
    logic [7:0] rx;
    int rv0;
    if (first) m_start(exp_tx);
    rv0 = rv_hi;
    spi_frame(mode, mb, nbits, first, hold, rx);
    if (nbits == 8) begin
      exp_rd = mb;
      chk("rd_valid_pulses", 32'(rv_hi - rv0), 32'd1);
      chk("data_rd", 32'(bus.data_rd), 32'(exp_rd));
      chk("miso_byte", 32'(rx), 32'(exp_tx));
      // cs still low after DONE: the responder reloads for a next frame.
      m_start(exp_tx);
    end else begin
      chk("abort_no_valid", 32'(rv_hi - rv0), 32'd0);
      chk("abort_data_rd", 32'(bus.data_rd), 32'(exp_rd));
    end
    if (!hold) begin
      chk("idle_state", 32'(bus.state), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_count", 32'(bus.count), 32'd8);
      chk("idle_miso", 32'(bus.miso), 32'd1);
      chk("idle_wr_ready", 32'(bus.wr_ready), 32'(TX_EN && !buf_full));
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_miso", 32'(bus.miso), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'(TX_EN));
    chk("rst_data_rd", 32'(bus.data_rd), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd8);
  endtask

  initial begin
    logic [1:0] md;
    logic [7:0] mb;
    reset        = 1'b1;
    bus.cs       = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.mosi     = 1'b0;
    bus.polarity = 1'b0;
    bus.phase    = 1'b0;
    bus.data_wr  = 8'h00;
    bus.wr_load  = 1'b0;
    #2;
    chk_reset_vals();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Mode 0 full duplex
    do_load(8'h3C);
    chk("wr_ready_after_load", 32'(bus.wr_ready), 32'd0);
    do_frame(2'd0, 8'hA5, 8, 1'b1, 1'b0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      do_load(8'hC3);
      do_frame(2'(m), 8'h5A, 8, 1'b1, 1'b0);
    end

    // Empty buffer sends all-ones
    do_frame(2'd0, 8'h81, 8, 1'b1, 1'b0);

    // Second write while full is dropped
    do_load(8'h12);
    do_load(8'h34);
    do_frame(2'd3, 8'h96, 8, 1'b1, 1'b0);

    // Abort after 4 bits; buffer stays consumed
    do_load(8'h4B);
    do_frame(2'd0, 8'hF0, 4, 1'b1, 1'b0);

    // Back-to-back frames, reload during the first one
    do_load(8'h6D);
    fork
      do_frame(2'd1, 8'h11, 8, 1'b1, 1'b1);
      begin
        repeat (30) @(negedge clk);
        do_load(8'hB2);
      end
    join
    do_frame(2'd1, 8'h22, 8, 1'b0, 1'b0);

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      md = 2'($urandom_range(0, 3));
      mb = 8'($urandom());
      if ($urandom_range(0, 1) == 1) do_load(8'($urandom()));
      do_frame(md, mb, 8, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-frame
    do_frame(2'd3, 8'h3E, 5, 1'b1, 1'b1);
    chk("mid_state", 32'(bus.state), 32'd2);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_count", 32'(bus.count), 32'd3);
    do_load(8'h99);
    chk("mid_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    buf_full = 1'b0;
    exp_rd   = 8'h00;
    #1;
    chk_reset_vals();
    @(negedge clk);
    bus.cs      = 1'b1;
    bus.spi_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    do_frame(2'd3, 8'h77, 8, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
